// File: rtl/length_scheduler.sv
// length_scheduler: pops per-lane row lengths from four length_fetchers and
// issues one element request per handshake, round-robin across busy lanes.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   run               1 = idle lanes may pop new row lengths
//   empty[3:0]        per-lane fetcher empty flags
//   lengths[31:0]     lane i head length at [8i+7:8i]
//   read[3:0]         per-lane pop strobe (combinational)
//   elem_valid/ready  element request handshake
//   elem_lane[1:0]    lane owning the current request
//   elem_last         current request is the row's final element
//   row_done[3:0]     registered one-cycle row-complete pulses
//   busy[3:0]         per-lane BUSY flag
//
// Optional feature (define LENGTH_SCHEDULER_STATS_EN):
//   rows_total[15:0]  saturating count of row_done pulses over all lanes
//   elems_total[15:0] wrapping count of element handshakes
module length_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [3:0]  empty,
   input  logic [31:0] lengths,
   output logic [3:0]  read,
   output logic        elem_valid,
   input  logic        elem_ready,
   output logic [1:0]  elem_lane,
   output logic        elem_last,
   output logic [3:0]  row_done,
   output logic [3:0]  busy
`ifdef LENGTH_SCHEDULER_STATS_EN
   ,
   output logic [15:0] rows_total,
   output logic [15:0] elems_total
`endif
);

   localparam logic IDLE = 1'b0;
   localparam logic BUSY = 1'b1;

   logic [3:0] state_q, state_d;
   logic [7:0] rem_q [4];
   logic [7:0] rem_d [4];
   logic [1:0] last_grant_q, last_grant_d;
   logic       hold_q;
   logic [1:0] hold_lane_q;
   logic [3:0] row_done_q, row_done_d;
   logic [1:0] grant;
   logic [1:0] idx;
   logic       found;
   logic       hs;

   // Pops only from idle lanes, so a popped length is consumed exactly once.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         read[i] = !rst && run && !empty[i] && (state_q[i] == IDLE);
      end
   end

   assign elem_valid = !rst && (|state_q);
   assign hs         = elem_valid && elem_ready;

   // Round-robin search from last_grant+1. While a request is stalled the
   // grant is frozen, otherwise a lane going busy mid-stall could steal it.
   always_comb begin
      grant = last_grant_q;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_grant_q + 2'(k);
         if (!found && (state_q[idx] == BUSY)) begin
            grant = idx;
            found = 1'b1;
         end
      end
      if (hold_q) grant = hold_lane_q;
   end

   assign elem_lane = grant;
   assign elem_last = (rem_q[grant] == 8'd1);

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      last_grant_d = last_grant_q;
      row_done_d   = 4'b0000;
      if (hs) begin
         rem_d[grant] = rem_q[grant] - 8'd1;
         last_grant_d = grant;
         if (elem_last) begin
            state_d[grant]    = IDLE;
            row_done_d[grant] = 1'b1;
         end
      end
      // read and handshake never target the same lane (IDLE vs BUSY).
      for (int i = 0; i < 4; i++) begin
         if (read[i]) begin
            rem_d[i] = lengths[8*i +: 8];
            if (lengths[8*i +: 8] == 8'd0) row_done_d[i] = 1'b1;
            else                           state_d[i]    = BUSY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= {4{IDLE}};
         for (int i = 0; i < 4; i++) rem_q[i] <= 8'd0;
         last_grant_q <= 2'd3;
         hold_q       <= 1'b0;
         hold_lane_q  <= 2'd0;
         row_done_q   <= 4'b0000;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         last_grant_q <= last_grant_d;
         hold_q       <= elem_valid && !elem_ready;
         hold_lane_q  <= grant;
         row_done_q   <= row_done_d;
      end
   end

   assign row_done = row_done_q;
   assign busy     = state_q;

`ifdef LENGTH_SCHEDULER_STATS_EN
   logic [15:0] rows_q, elems_q;
   logic [15:0] done_cnt;

   always_comb begin
      done_cnt = 16'd0;
      for (int i = 0; i < 4; i++) done_cnt = done_cnt + 16'(row_done_q[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q  <= 16'd0;
         elems_q <= 16'd0;
      end else begin
         if (rows_q > (16'hFFFF - done_cnt)) rows_q <= 16'hFFFF;
         else                                rows_q <= rows_q + done_cnt;
         elems_q <= elems_q + 16'(hs);
      end
   end

   assign rows_total  = rows_q;
   assign elems_total = elems_q;
`endif

endmodule

// File: doc/length_scheduler.md
LENGTH_SCHEDULER -- requirements
Module: length_scheduler

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port run, input, 1: 1 = lanes may pop new row lengths.
REQ-004 SHALL have port empty, input, 4: per-lane length_fetcher empty flags.
REQ-005 SHALL have port lengths, input, 32: lane i head length at bits [8i+7:8i], valid while empty[i]=0.
REQ-006 SHALL have port read, output, 4: per-lane one-cycle pop strobe to length_fetcher.
REQ-007 SHALL have port elem_valid, output, 1: element request pending.
REQ-008 SHALL have port elem_ready, input, 1: element port accepts request.
REQ-009 SHALL have port elem_lane, output, 2: lane owning current request.
REQ-010 SHALL have port elem_last, output, 1: current request is the row's final element.
REQ-011 SHALL have port row_done, output, 4: per-lane one-cycle row-complete pulse.
REQ-012 SHALL have port busy, output, 4: per-lane BUSY state flag.

Function
REQ-013 SHALL keep per lane a 2-state FSM (IDLE, BUSY) and an 8-bit remaining counter rem[i].
REQ-014 SHALL assert read[i] combinationally in IDLE when run=1 and empty[i]=0; same edge captures lengths[8i+7:8i] into rem[i].
REQ-015 SHALL on a captured length of 0 stay IDLE, issue no requests, and pulse row_done[i] the following cycle.
REQ-016 SHALL on a captured nonzero length move to BUSY on that edge; busy[i]=1 from the next cycle.
REQ-017 SHALL never assert read[i] while lane i is BUSY; a popped length is consumed exactly once.
REQ-018 SHALL drive elem_valid=1 whenever any lane is BUSY, combinationally.
REQ-019 SHALL select elem_lane round-robin among BUSY lanes, searching from (last_grant+1) mod 4.
REQ-020 SHALL hold elem_lane and elem_last stable while elem_valid=1 and elem_ready=0.
REQ-021 SHALL on handshake (elem_valid & elem_ready) decrement rem of the granted lane and set last_grant to it.
REQ-022 SHALL drive elem_last=1 when granted lane has rem=1; on that handshake lane returns to IDLE and row_done pulses next cycle.
REQ-023 SHALL let a lane returning to IDLE pop again no earlier than the cycle after its final handshake.
REQ-024 SHALL register row_done; at most one cycle high per completed row; multiple lanes may pulse simultaneously.
REQ-025 SHALL, when run=0, pop nothing while BUSY lanes complete their rows normally.
REQ-026 SHALL handle maximum length 255 without counter wrap.

Reset
REQ-027 SHALL on rst=1 force all lanes IDLE, rem=0, last_grant=3 (lane 0 first), row_done=0, read=0, elem_valid=0.
REQ-028 SHALL abandon in-flight rows on reset mid-operation with no row_done pulse; rst overrides all handshakes that cycle.

Configuration
REQ-029 SHALL, when LENGTH_SCHEDULER_STATS_EN is defined, add output rows_total (16 bits, saturating at 65535) counting row_done pulses summed over lanes, and output elems_total (16 bits, wrapping) counting handshakes; both cleared by rst.
REQ-030 SHALL, without LENGTH_SCHEDULER_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-031 SHALL verify: rst, run=1, lane0 length 3, elem_ready=1 -> read[0] one cycle, 3 handshakes lane 0, elem_last on 3rd, row_done[0] next cycle.
REQ-032 SHALL verify: lanes 0-3 lengths 2,2,2,2 popped together, elem_ready=1 -> grant order 0,1,2,3,0,1,2,3; row_done pulses follow final grants.
REQ-033 SHALL verify: lane 2 length 0 -> read[2] pulse, no elem_valid for lane 2, row_done[2] next cycle.
REQ-034 SHALL verify: elem_ready=0 for 5 cycles with lane 1 BUSY rem=4 -> elem_lane=1 and rem stable; rem 4->3 after ready rises.
REQ-035 SHALL verify: rst asserted after 2 of 5 elements -> all outputs zero next cycle, no row_done; post-reset pop starts fresh.
REQ-036 SHALL verify: run=0 during lane 3 row length 4 -> row completes, no further read[3] while empty[3]=0.
